// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data memory responder: FSM state encoding,
// default base address and the request range/alignment check.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ADDRESS_BASE = 32'h00002000;

  // Offset is taken modulo 2^32, so addresses below the base land far out of range.
  function automatic logic address_error(input logic [31:0] address,
                                         input logic [31:0] base,
                                         input logic [31:0] span_bytes);
    logic [31:0] offset;
    offset = address - base;
    return (address[1:0] != 2'b00) || (offset >= span_bytes);
  endfunction

endpackage

// File: rtl/data_memory_responder_dmem_array.sv
// Word-wide storage with byte-lane writes and a registered read port.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic [3:0]            byte_enable,
  output logic [31:0]           read_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write port
  always_ff @(posedge clock) begin
    if (write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) begin
          mem[address][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port, updated only when a load commits
  always_ff @(posedge clock) begin
    if (read_enable) begin
      read_data <= mem[address];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding memory responder: accepts one request in IDLE, waits
// WAIT_STATES cycles, commits the access and holds the response until consumed.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter logic [31:0] ADDRESS_BASE = DEFAULT_ADDRESS_BASE,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          WAIT_STATES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [3:0]  req_byte_enable,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int          ADDR_WIDTH = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t state, next_state;
  logic [3:0] count, next_count;
  logic accept, commit;

  logic        held_write;
  logic [31:0] held_address, held_write_data;
  logic [3:0]  held_byte_enable;

  logic        op_write, op_error;
  logic [31:0] op_address, op_write_data;
  logic [3:0]  op_byte_enable;
  logic [ADDR_WIDTH-1:0] word_index;
  logic        mem_write, mem_read;
  logic        load_ok;
  logic [31:0] array_data;

  assign req_ready = (state == IDLE);

  // Next-state, counter and commit decode
  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = RESPOND;
            commit     = 1'b1;
          end else begin
            next_state = WAIT;
            next_count = WAIT_LOAD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          next_state = RESPOND;
          commit     = 1'b1;
        end else begin
          next_count = count - 4'd1;
        end
      end
      RESPOND: begin
        if (resp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESPOND;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = 4'd0;
      end
    endcase
  end

  // With zero wait states the commit happens on the acceptance edge, so the live inputs are used
  always_comb begin
    if (state == IDLE) begin
      op_write       = req_write;
      op_address     = req_address;
      op_write_data  = req_write_data;
      op_byte_enable = req_byte_enable;
    end else begin
      op_write       = held_write;
      op_address     = held_address;
      op_write_data  = held_write_data;
      op_byte_enable = held_byte_enable;
    end
    op_error   = address_error(op_address, ADDRESS_BASE, SPAN_BYTES);
    word_index = ADDR_WIDTH'((op_address - ADDRESS_BASE) >> 2);
    mem_write  = commit && op_write && !op_error && !reset;
    mem_read   = commit && !op_write && !op_error && !reset;
  end

  // State and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      held_write       <= 1'b0;
      held_address     <= 32'h0;
      held_write_data  <= 32'h0;
      held_byte_enable <= 4'h0;
    end else if (accept) begin
      held_write       <= req_write;
      held_address     <= req_address;
      held_write_data  <= req_write_data;
      held_byte_enable <= req_byte_enable;
    end
  end

  // Response flags, set on commit and cleared when the response is consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      load_ok    <= 1'b0;
    end else if (commit) begin
      resp_valid <= 1'b1;
      resp_error <= op_error;
      load_ok    <= !op_write && !op_error;
    end else if (state == RESPOND && resp_ready) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      load_ok    <= 1'b0;
    end
  end

  assign resp_read_data = load_ok ? array_data : 32'h0;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clock       (clock),
    .write_enable(mem_write),
    .read_enable (mem_read),
    .address     (word_index),
    .write_data  (op_write_data),
    .byte_enable (op_byte_enable),
    .read_data   (array_data)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized and directed bench for data_memory_responder: one instance with
// two wait states, one with none, both compared against a word-array model.
module tb_data_memory_responder;

  localparam logic [31:0] BASE = 32'h00002000;
  localparam int WORDS = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_write_data = 32'h0;
  logic [3:0]  req_byte_enable = 4'h0;
  logic resp_ready = 1'b0;
  logic sel = 1'b0;

  logic req_valid_a, req_valid_b;
  logic req_ready_a, resp_valid_a, resp_error_a;
  logic req_ready_b, resp_valid_b, resp_error_b;
  logic [31:0] resp_read_data_a, resp_read_data_b;
  logic o_req_ready, o_resp_valid, o_resp_error;
  logic [31:0] o_resp_read_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_a [WORDS];
  logic [31:0] model_b [WORDS];

  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid && sel;
  assign o_req_ready      = sel ? req_ready_b      : req_ready_a;
  assign o_resp_valid     = sel ? resp_valid_b     : resp_valid_a;
  assign o_resp_error     = sel ? resp_error_b     : resp_error_a;
  assign o_resp_read_data = sel ? resp_read_data_b : resp_read_data_a;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDRESS_BASE(BASE), .DEPTH_WORDS(WORDS), .WAIT_STATES(2)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable), .resp_valid(resp_valid_a), .resp_ready(resp_ready && !sel),
    .resp_read_data(resp_read_data_a), .resp_error(resp_error_a));

  data_memory_responder #(.ADDRESS_BASE(BASE), .DEPTH_WORDS(WORDS), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
    .req_byte_enable(req_byte_enable), .resp_valid(resp_valid_b), .resp_ready(resp_ready && sel),
    .resp_read_data(resp_read_data_b), .resp_error(resp_error_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_error(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * WORDS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One full request/response; garbage is driven on the request bus while busy.
  task automatic transact(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
    int n;
    sel = s;
    rd = 32'h0; er = 1'b0; lat = 0;
    @(negedge clock);
    resp_ready = 1'b0;
    req_write = w; req_address = a; req_write_data = d; req_byte_enable = be; req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) begin check("accept_timeout", 32'd1, 32'd0); req_valid = 1'b0; return; end
    @(posedge clock);
    @(negedge clock);
    req_write = 1'($urandom); req_address = $urandom; req_write_data = $urandom;
    req_byte_enable = 4'($urandom);
    lat = 1;
    while (!o_resp_valid && lat < 40) begin
      check("busy_req_ready", 32'(o_req_ready), 32'd0);
      @(negedge clock);
      lat++;
    end
    if (!o_resp_valid) begin check("resp_timeout", 32'd1, 32'd0); req_valid = 1'b0; return; end
    rd = o_resp_read_data;
    er = o_resp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(o_resp_valid), 32'd1);
      check("hold_data", o_resp_read_data, rd);
      check("hold_error", 32'(o_resp_error), 32'(er));
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check("release_valid", 32'(o_resp_valid), 32'd0);
    check("release_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic er, w;
    logic [3:0] be;
    int lat, idx;

    // Reset state on both instances
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst_resp_error", 32'(o_resp_error), 32'd0);
      check("rst_read_data", o_resp_read_data, 32'h0);
    end
    reset = 1'b0;

    // Full-word store then load, with latency check
    transact(1'b0, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st_lat", 32'(lat), 32'd3);
    check("st_data", rd, 32'h0);
    check("st_err", 32'(er), 32'd0);
    transact(1'b0, 1'b0, 32'h2004, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_data", rd, 32'hDEADBEEF);
    check("ld_err", 32'(er), 32'd0);

    // Single-lane store
    transact(1'b0, 1'b1, 32'h2004, 32'h000000AA, 4'h1, 0, rd, er, lat);
    transact(1'b0, 1'b0, 32'h2004, 32'h0, 4'h0, 0, rd, er, lat);
    check("lane_data", rd, 32'hDEADBEAA);

    // Misaligned and out-of-range loads
    transact(1'b0, 1'b0, 32'h2002, 32'h0, 4'h0, 0, rd, er, lat);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_data", rd, 32'h0);
    transact(1'b0, 1'b0, 32'h3000, 32'h0, 4'h0, 0, rd, er, lat);
    check("range_err", 32'(er), 32'd1);
    check("range_data", rd, 32'h0);
    transact(1'b0, 1'b1, 32'h1FFC, 32'h11111111, 4'hF, 0, rd, er, lat);
    check("below_base_err", 32'(er), 32'd1);

    // Back-pressure for five cycles
    transact(1'b0, 1'b0, 32'h2004, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_data", rd, 32'hDEADBEAA);
    check("bp_err", 32'(er), 32'd0);
    model_a[1] = 32'hDEADBEAA;

    // Prefill a pool at both ends of the array, then random traffic
    for (int i = 0; i < 32; i++) begin
      idx = (i < 16) ? i : WORDS - 32 + i;
      d = $urandom;
      model_a[idx] = d;
      transact(1'b0, 1'b1, BASE + 32'(4 * idx), d, 4'hF, 0, rd, er, lat);
    end
    for (int k = 0; k < 60; k++) begin
      idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(WORDS - 16, WORDS - 1);
      a = BASE + 32'(4 * idx);
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 8));
        2: a = BASE - 32'(4 * $urandom_range(1, 8));
        default: a = a;
      endcase
      w = 1'($urandom);
      d = $urandom;
      be = 4'($urandom);
      transact(1'b0, w, a, d, be, $urandom_range(0, 3), rd, er, lat);
      check("rnd_lat", 32'(lat), 32'd3);
      check("rnd_err", 32'(er), 32'(exp_error(a)));
      if (exp_error(a) || w) begin
        check("rnd_data", rd, 32'h0);
      end else begin
        check("rnd_data", rd, model_a[(a - BASE) / 4]);
      end
      if (w && !exp_error(a)) model_a[(a - BASE) / 4] = merge(model_a[(a - BASE) / 4], d, be);
    end

    // Reset while a store waits: store is dropped, no response appears
    sel = 1'b0;
    @(negedge clock);
    req_write = 1'b1; req_address = 32'h2004; req_write_data = 32'h12345678;
    req_byte_enable = 4'hF; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("wrst_req_ready", 32'(o_req_ready), 32'd1);
    check("wrst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("wrst_read_data", o_resp_read_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wrst_no_resp", 32'(o_resp_valid), 32'd0);
    end
    transact(1'b0, 1'b0, 32'h2004, 32'h0, 4'h0, 0, rd, er, lat);
    check("wrst_word", rd, model_a[1]);

    // Zero wait states: prefill, then back-to-back loads with resp_ready held high
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      model_b[i] = d;
      transact(1'b1, 1'b1, BASE + 32'(4 * i), d, 4'hF, 0, rd, er, lat);
      check("b_st_lat", 32'(lat), 32'd1);
    end
    sel = 1'b1;
    @(negedge clock);
    resp_ready = 1'b1;
    req_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        check("b2b_req_ready", 32'(o_req_ready), 32'd1);
        check("b2b_idle_valid", 32'(o_resp_valid), 32'd0);
        req_address = BASE + 32'(4 * (k / 2));
        req_valid = 1'b1;
      end else begin
        check("b2b_valid", 32'(o_resp_valid), 32'd1);
        check("b2b_busy_ready", 32'(o_req_ready), 32'd0);
        check("b2b_data", o_resp_read_data, model_b[k / 2]);
        req_address = $urandom;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clock);
    check("b2b_end_idle", 32'(o_req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
